// File: rtl/i2s_pkg.sv
// ============================================================================
// i2s_pkg : shared constants, state encoding and bit/channel helpers | rev 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int DEF_MCLK_DIV  = 4;
  localparam int DEF_BCLK_DIV  = 16;
  localparam int DEF_SLOT_BITS = 32;
  localparam int SLOT_BITS_MIN = 8;
  localparam int SLOT_BITS_MAX = 32;

  localparam int I2S_PHILIPS = 1;
  localparam int I2S_LJ      = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic slot_is_right(input int f, input int slot_bits);
    return (f >= slot_bits);
  endfunction

  function automatic int slot_bit_idx(input int f, input int slot_bits);
    return (f >= slot_bits) ? (2 * slot_bits - 1 - f) : (slot_bits - 1 - f);
  endfunction

  // Philips mode announces the channel of the following bit.
  function automatic logic lr_for(input int f, input int slot_bits, input int delay);
    int g;
    if (delay != 0) begin
      g = (f == 2 * slot_bits - 1) ? 0 : f + 1;
    end else begin
      g = f;
    end
    return (g >= slot_bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_clk_div.sv
// ============================================================================
// i2s_clk_div : even divider, 50% output, registered rise/fall strobes | rev 1.0
// ============================================================================
`default_nettype none

module i2s_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic clk_out,
  output logic rise_stb,
  output logic fall_stb,
  output logic wrap
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  logic [CW-1:0] cnt;

  // Asserted in the cycle before the counter returns to zero.
  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else if (en) begin
      cnt      <= wrap ? '0 : cnt + 1'b1;
      rise_stb <= (cnt == HALF_M1);
      fall_stb <= wrap;
      if (cnt == HALF_M1) begin
        clk_out <= 1'b1;
      end else if (wrap) begin
        clk_out <= 1'b0;
      end
    end else begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// i2s_clk_gen : MCLK/BCLK/LRCLK generator with frame-aligned start/stop | rev 1.0
// ============================================================================
`default_nettype none

module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV  = DEF_MCLK_DIV,
  parameter int BCLK_DIV  = DEF_BCLK_DIV,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int I2S_DELAY = I2S_PHILIPS
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         en,
  output logic                         mclk,
  output logic                         bclk,
  output logic                         lrclk,
  output logic                         bclk_fall_stb,
  output logic                         bclk_rise_stb,
  output logic                         frame_stb,
  output logic                         ch_right,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
  output logic                         active
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int FW         = $clog2(FRAME_BITS);
  localparam int BW         = $clog2(SLOT_BITS);
  localparam logic [FW-1:0] F_LAST  = FW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] BIT_TOP = BW'(SLOT_BITS - 1);

  if ((MCLK_DIV < 2) || (MCLK_DIV % 2 != 0) || (BCLK_DIV < 2) || (BCLK_DIV % 2 != 0) ||
      (SLOT_BITS < SLOT_BITS_MIN) || (SLOT_BITS > SLOT_BITS_MAX) ||
      ((I2S_DELAY != I2S_PHILIPS) && (I2S_DELAY != I2S_LJ))) begin : g_param_check
    $error("i2s_clk_gen: illegal parameter set");
  end

  state_t        state;
  logic [FW-1:0] f_cnt;
  logic [FW-1:0] f_inc;
  logic          b_wrap;
  logic          b_fall_unused;
  logic          m_rise_unused, m_fall_unused, m_wrap_unused;
  logic          unused_div;

  assign unused_div = ^{b_fall_unused, m_rise_unused, m_fall_unused, m_wrap_unused};
  assign f_inc      = (f_cnt == F_LAST) ? '0 : f_cnt + 1'b1;

  i2s_clk_div #(.DIV(MCLK_DIV)) u_mclk_div (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .en       (1'b1),
    .clr      (1'b0),
    .clk_out  (mclk),
    .rise_stb (m_rise_unused),
    .fall_stb (m_fall_unused),
    .wrap     (m_wrap_unused)
  );

  i2s_clk_div #(.DIV(BCLK_DIV)) u_bclk_div (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .en       (state == ST_RUN),
    .clr      (state == ST_IDLE),
    .clk_out  (bclk),
    .rise_stb (bclk_rise_stb),
    .fall_stb (b_fall_unused),
    .wrap     (b_wrap)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      f_cnt         <= '0;
      active        <= 1'b0;
      bclk_fall_stb <= 1'b0;
      frame_stb     <= 1'b0;
      ch_right      <= 1'b0;
      lrclk         <= 1'b0;
      bit_idx       <= BIT_TOP;
    end else begin
      bclk_fall_stb <= 1'b0;
      frame_stb     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state         <= ST_RUN;
            active        <= 1'b1;
            f_cnt         <= '0;
            bclk_fall_stb <= 1'b1;
            frame_stb     <= 1'b1;
            ch_right      <= 1'b0;
            bit_idx       <= BIT_TOP;
            lrclk         <= lr_for(0, SLOT_BITS, I2S_DELAY);
          end
        end
        ST_RUN: begin
          if (b_wrap) begin
            // en is only honoured at the frame boundary.
            if ((f_cnt == F_LAST) && !en) begin
              state    <= ST_IDLE;
              active   <= 1'b0;
              f_cnt    <= '0;
              ch_right <= 1'b0;
              bit_idx  <= BIT_TOP;
              lrclk    <= 1'b0;
            end else begin
              f_cnt         <= f_inc;
              bclk_fall_stb <= 1'b1;
              frame_stb     <= (f_cnt == F_LAST);
              ch_right      <= slot_is_right(int'(f_inc), SLOT_BITS);
              bit_idx       <= BW'(slot_bit_idx(int'(f_inc), SLOT_BITS));
              lrclk         <= lr_for(int'(f_inc), SLOT_BITS, I2S_DELAY);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_clk_gen.sv
// ============================================================================
// tb_i2s_clk_gen : randomized bench for i2s_clk_gen against a timing model | rev 1.0
// ============================================================================
`default_nettype none

module tb_i2s_clk_gen;

  localparam int A_MD = 4, A_BD = 16, A_S = 32, A_DLY = 1;
  localparam int A_FRAME = A_BD * 2 * A_S;
  localparam int B_MD = 2, B_BD = 2, B_S = 16, B_DLY = 0;
  localparam int B_FRAME = B_BD * 2 * B_S;
  localparam logic [12:0] A_RESET = {7'b0, 5'd31, 1'b0};

  logic clk_in = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, rst_n2 = 1'b0, en2 = 1'b0;

  logic a_mclk, a_bclk, a_lrclk, a_fall, a_rise, a_frame, a_ch, a_active;
  logic [4:0] a_bit;
  logic b_mclk, b_bclk, b_lrclk, b_fall, b_rise, b_frame, b_ch, b_active;
  logic [3:0] b_bit;

  int compared = 0, mismatched = 0;
  int a_m = 0, a_t = 0, b_m = 0, b_t = 0;
  bit a_run = 0, b_run = 0;

  always #5 clk_in = ~clk_in;

  i2s_clk_gen dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .mclk(a_mclk), .bclk(a_bclk),
    .lrclk(a_lrclk), .bclk_fall_stb(a_fall), .bclk_rise_stb(a_rise),
    .frame_stb(a_frame), .ch_right(a_ch), .bit_idx(a_bit), .active(a_active)
  );

  i2s_clk_gen #(.MCLK_DIV(B_MD), .BCLK_DIV(B_BD), .SLOT_BITS(B_S), .I2S_DELAY(B_DLY)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n2), .en(en2), .mclk(b_mclk), .bclk(b_bclk),
    .lrclk(b_lrclk), .bclk_fall_stb(b_fall), .bclk_rise_stb(b_rise),
    .frame_stb(b_frame), .ch_right(b_ch), .bit_idx(b_bit), .active(b_active)
  );

  function automatic logic [12:0] a_obs();
    return {a_mclk, a_bclk, a_lrclk, a_fall, a_rise, a_frame, a_ch, a_bit, a_active};
  endfunction

  function automatic logic [12:0] b_obs();
    return {b_mclk, b_bclk, b_lrclk, b_fall, b_rise, b_frame, b_ch, 1'b0, b_bit, b_active};
  endfunction

  // Expected outputs from cycles since reset (m) and cycles since frame start (t).
  function automatic logic [12:0] model_out(input int md, input int bd, input int s,
                                            input int dly, input int m, input bit run,
                                            input int t);
    logic [12:0] v;
    int f, ph;
    v     = '0;
    v[12] = (m >= md / 2);
    if (run) begin
      f      = t / bd;
      ph     = t % bd;
      v[11]  = (ph >= bd / 2);
      v[10]  = (dly != 0) ? (((f + 1) % (2 * s)) >= s) : (f >= s);
      v[9]   = (ph == 0);
      v[8]   = (ph == bd / 2);
      v[7]   = (t == 0);
      v[6]   = (f >= s);
      v[5:1] = 5'(s - 1 - (f % s));
      v[0]   = 1'b1;
    end else begin
      v[5:1] = 5'(s - 1);
    end
    return v;
  endfunction

  task automatic model_step(input int md, input int frame, input logic r, input logic e,
                            inout int m, inout bit run, inout int t);
    if (!r) begin
      m = 0; run = 0; t = 0;
    end else begin
      m = (m + 1) % md;
      if (!run) begin
        if (e) begin run = 1; t = 0; end
      end else if (t == frame - 1) begin
        if (e) t = 0;
        else begin run = 0; t = 0; end
      end else begin
        t++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step(A_MD, A_FRAME, rst_n, en, a_m, a_run, a_t);
    model_step(B_MD, B_FRAME, rst_n2, en2, b_m, b_run, b_t);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] exp_v;
    rst_n = 1'b0; en = 1'b1;
    repeat (3) tick();
    compared++;
    if (a_obs() !== A_RESET) begin
      mismatched++;
      $display("FAIL reset_vec: got %b want %b", a_obs(), A_RESET);
    end
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      exp_v = model_out(A_MD, A_BD, A_S, A_DLY, a_m, a_run, a_t);
      compared++;
      if (a_obs() !== exp_v) begin
        mismatched++;
        $display("FAIL idle_after_reset cyc %0d: got %b want %b", i, a_obs(), exp_v);
      end
    end
  endtask

  task automatic test_start();
    logic [12:0] exp_v;
    int first_rise, first_lr, first_ch;
    rst_n = 1'b0; tick(); rst_n = 1'b1; en = 1'b0;
    repeat (5) tick();
    en = 1'b1; tick();
    compared++;
    if (a_frame !== 1'b1 || a_fall !== 1'b1 || a_active !== 1'b1 || a_bit !== 5'd31) begin
      mismatched++;
      $display("FAIL start_edge: got frame=%b fall=%b active=%b bit=%0d want 1 1 1 31",
               a_frame, a_fall, a_active, a_bit);
    end
    first_rise = -1; first_lr = -1; first_ch = -1;
    for (int i = 1; i <= 600; i++) begin
      tick();
      exp_v = model_out(A_MD, A_BD, A_S, A_DLY, a_m, a_run, a_t);
      compared++;
      if (a_obs() !== exp_v) begin
        mismatched++;
        $display("FAIL start_run cyc %0d: got %b want %b", i, a_obs(), exp_v);
      end
      if (a_rise === 1'b1 && first_rise < 0) first_rise = i;
      if (a_lrclk === 1'b1 && first_lr < 0) first_lr = i;
      if (a_ch === 1'b1 && first_ch < 0) first_ch = i;
    end
    compared++;
    if (first_rise != 8 || first_lr != 496 || first_ch != 512) begin
      mismatched++;
      $display("FAIL start_offsets: got rise=%0d lr=%0d ch=%0d want 8 496 512",
               first_rise, first_lr, first_ch);
    end
  endtask

  task automatic test_stop_mid_frame();
    logic [12:0] exp_v;
    int drop, rises, idle_bad;
    for (int k = 0; k < 3; k++) begin
      drop = (k == 0) ? 10 * A_BD : int'($urandom_range(1, A_FRAME - 2));
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      en = 1'b1; tick();
      rises = 0; idle_bad = 0;
      for (int i = 1; i < A_FRAME + 40; i++) begin
        tick();
        exp_v = model_out(A_MD, A_BD, A_S, A_DLY, a_m, a_run, a_t);
        compared++;
        if (a_obs() !== exp_v) begin
          mismatched++;
          $display("FAIL stop_run k%0d cyc %0d: got %b want %b", k, i, a_obs(), exp_v);
        end
        if (i < A_FRAME && a_rise === 1'b1) rises++;
        if (i >= A_FRAME && (a_frame || a_active || a_bclk || a_lrclk)) idle_bad++;
        if (i == drop) en = 1'b0;
      end
      compared++;
      if (rises != 64 || idle_bad != 0) begin
        mismatched++;
        $display("FAIL stop_frame k%0d: got rises=%0d idle_bad=%0d want 64 0", k, rises, idle_bad);
      end
      repeat ($urandom_range(0, 20)) tick();
      en = 1'b1; tick();
      compared++;
      if (a_frame !== 1'b1 || a_active !== 1'b1) begin
        mismatched++;
        $display("FAIL restart k%0d: got frame=%b active=%b want 1 1", k, a_frame, a_active);
      end
      en = 1'b0;
      repeat (A_FRAME + 2) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_v;
    int last_frame, frames, falls, pos;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    en = 1'b1; tick();
    last_frame = 0; frames = 1; falls = 0;
    for (int i = 1; i <= 3 * A_FRAME; i++) begin
      tick();
      exp_v = model_out(A_MD, A_BD, A_S, A_DLY, a_m, a_run, a_t);
      compared++;
      if (a_obs() !== exp_v) begin
        mismatched++;
        $display("FAIL cont_run cyc %0d: got %b want %b", i, a_obs(), exp_v);
      end
      if (a_frame === 1'b1) begin
        frames++;
        compared++;
        if (i - last_frame != A_FRAME) begin
          mismatched++;
          $display("FAIL frame_period: got %0d want %0d", i - last_frame, A_FRAME);
        end
        last_frame = i;
      end
      if (a_fall === 1'b1) begin
        falls++;
        compared++;
        if (a_bit !== 5'(31 - (falls % 32))) begin
          mismatched++;
          $display("FAIL bit_seq fall %0d: got %0d want %0d", falls, a_bit, 31 - (falls % 32));
        end
      end
      // Mid-frame en noise must not stop the stream; hold en high at every boundary.
      pos = (i + 1) % A_FRAME;
      en  = (pos == 0 || pos >= A_FRAME - 4) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    compared++;
    if (frames != 4) begin
      mismatched++;
      $display("FAIL frame_count: got %0d want 4", frames);
    end
    en = 1'b0;
  endtask

  task automatic test_small_cfg();
    logic [12:0] exp_v;
    logic prev;
    int last_frame;
    rst_n2 = 1'b0; tick(); rst_n2 = 1'b1;
    en2 = 1'b1; tick();
    prev = b_bclk; last_frame = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      exp_v = model_out(B_MD, B_BD, B_S, B_DLY, b_m, b_run, b_t);
      compared++;
      if (b_obs() !== exp_v) begin
        mismatched++;
        $display("FAIL small_run cyc %0d: got %b want %b", i, b_obs(), exp_v);
      end
      compared++;
      if (b_lrclk !== b_ch || b_bclk === prev || b_rise === b_fall) begin
        mismatched++;
        $display("FAIL small_shape cyc %0d: got lr=%b ch=%b bclk=%b prev=%b rise=%b fall=%b",
                 i, b_lrclk, b_ch, b_bclk, prev, b_rise, b_fall);
      end
      prev = b_bclk;
      if (b_frame === 1'b1) begin
        compared++;
        if (i - last_frame != B_FRAME) begin
          mismatched++;
          $display("FAIL small_frame_period: got %0d want %0d", i - last_frame, B_FRAME);
        end
        last_frame = i;
      end
    end
    for (int i = 0; i < 400; i++) begin
      en2 = 1'($urandom_range(0, 1));
      tick();
      exp_v = model_out(B_MD, B_BD, B_S, B_DLY, b_m, b_run, b_t);
      compared++;
      if (b_obs() !== exp_v) begin
        mismatched++;
        $display("FAIL small_rand cyc %0d: got %b want %b", i, b_obs(), exp_v);
      end
    end
    en2 = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] exp_v;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    en = 1'b1; tick();
    repeat (40 * A_BD) tick();
    rst_n = 1'b0; tick();
    compared++;
    if (a_obs() !== A_RESET) begin
      mismatched++;
      $display("FAIL midframe_reset: got %b want %b", a_obs(), A_RESET);
    end
    rst_n = 1'b1; tick();
    compared++;
    if (a_frame !== 1'b1 || a_lrclk !== 1'b0 || a_active !== 1'b1) begin
      mismatched++;
      $display("FAIL midframe_restart: got frame=%b lr=%b active=%b want 1 0 1",
               a_frame, a_lrclk, a_active);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      exp_v = model_out(A_MD, A_BD, A_S, A_DLY, a_m, a_run, a_t);
      compared++;
      if (a_obs() !== exp_v) begin
        mismatched++;
        $display("FAIL midframe_run cyc %0d: got %b want %b", i, a_obs(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop_mid_frame();
    test_back_to_back();
    test_small_cfg();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
